if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the LC-3b pipeline. Holds the PC and runs the instruction-memory read handshake. Drives `IF_ID_ir`/`IF_ID_pc` into decode and the hazard unit, and consumes `gen_bubble`/`squash_ID` from that unit plus the taken-redirect from the branch-resolving stage.

---
 rtl/lc3b_types.sv | 32 +++
 rtl/if_stage_if.sv | 12 +
 rtl/if_stage_fetch_skid_buf.sv | 39 +++
 rtl/if_stage.sv | 201 ++++++++++++++++++++
 tb/tb_if_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: NOP encoding, fetch FSM states, opcode helpers.
package lc3b_types;

    localparam logic [15:0] lc3b_nop = 16'h0000;

    localparam logic [3:0] op_br   = 4'b0000;
    localparam logic [3:0] op_jsr  = 4'b0100;
    localparam logic [3:0] op_jmp  = 4'b1100;
    localparam logic [3:0] op_trap = 4'b1111;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        DRAIN    = 2'd1,
        BUFFERED = 2'd2
    } if_state_t;

    // True for opcodes that change control flow (branch, jump, subroutine, trap).
    function automatic logic is_ctl(input logic [3:0] opcode);
        logic ctl;
        case (opcode)
            op_br, op_jsr, op_jmp, op_trap: ctl = 1'b1;
            default:                        ctl = 1'b0;
        endcase
        return ctl;
    endfunction

    // Sequential PC step; 16-bit modulo so FFFE wraps to 0000.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
    logic [15:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [15:0] imem_rdata;

    modport master (output imem_address, output imem_read,
                    input  imem_resp,    input  imem_rdata);
    modport slave  (input  imem_address, input  imem_read,
                    output imem_resp,    output imem_rdata);
endinterface

// File: rtl/if_stage_fetch_skid_buf.sv
// One-entry {ir, pc} holding buffer for a response that arrives while the stage is frozen.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] ir_in,
    input  logic [15:0] pc_in,
    output logic        valid,
    output logic [15:0] ir,
    output logic [15:0] pc
);

    logic        valid_r;
    logic [15:0] ir_r;
    logic [15:0] pc_r;

    // Clear wins over load so a redirect or squash always drops the stale entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            ir_r    <= 16'h0000;
            pc_r    <= 16'h0000;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            ir_r    <= ir_in;
            pc_r    <= pc_in;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign ir    = ir_r;
    assign pc    = pc_r;

endmodule

// File: rtl/if_stage.sv
// LC-3b instruction-fetch stage with IF/ID pipeline register.
// Optional IF_STAGE_SKID_EN: keep a response that arrives while frozen in a
// one-entry buffer instead of discarding it and refetching.
module if_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    if_stage_if.master        imem,
    input  logic              gen_bubble,
    input  logic              squash_ID,
    input  logic              stall_mem,
    input  logic              pc_load,
    input  logic [15:0]       pc_target,
    output logic [15:0]       IF_ID_ir,
    output logic [15:0]       IF_ID_pc,
    output logic              IF_ID_valid
);

    if_state_t   state_r;
    logic [15:0] pc_r;
    logic [15:0] imem_address_r;
    logic        imem_read_r;
    logic [15:0] ir_r;
    logic [15:0] ifid_pc_r;
    logic        valid_r;

    logic        adv_s;
    logic        ctl_s;
    logic        load_ifid_s;
    logic [15:0] load_ir_s;
    logic [15:0] load_pc_s;

`ifdef IF_STAGE_SKID_EN
    logic        skid_load_s;
    logic        skid_clear_s;
    logic        skid_valid_s;
    logic [15:0] skid_ir_s;
    logic [15:0] skid_pc_s;

    // Capture a live response when the stage cannot accept it; drop on redirect, squash or drain.
    always_comb begin
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if ((state_r == FETCH) && imem_read_r && imem.imem_resp && !adv_s && !pc_load && !squash_ID) begin
            skid_load_s = 1'b1;
        end else begin
            skid_load_s = 1'b0;
        end
        if (pc_load || squash_ID || ((state_r == BUFFERED) && adv_s)) begin
            skid_clear_s = 1'b1;
        end else begin
            skid_clear_s = 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load_s),
        .clear (skid_clear_s),
        .ir_in (imem.imem_rdata),
        .pc_in (pc_inc(pc_r)),
        .valid (skid_valid_s),
        .ir    (skid_ir_s),
        .pc    (skid_pc_s)
    );
`endif

    // Advance qualifier, control-flow detect on IF/ID, and the candidate IF/ID load source.
    always_comb begin
        adv_s       = !stall_mem && !gen_bubble;
        ctl_s       = (ir_r != lc3b_nop) && is_ctl(ir_r[15:12]);
        load_ifid_s = 1'b0;
        load_ir_s   = imem.imem_rdata;
        load_pc_s   = pc_inc(pc_r);
        if ((state_r == FETCH) && imem_read_r && imem.imem_resp) begin
            load_ifid_s = 1'b1;
`ifdef IF_STAGE_SKID_EN
        end else if (state_r == BUFFERED) begin
            load_ifid_s = skid_valid_s;
            load_ir_s   = skid_ir_s;
            load_pc_s   = skid_pc_s;
`endif
        end else begin
            load_ifid_s = 1'b0;
        end
    end

    // Fetch FSM, PC and IF/ID register; redirect outranks squash, stall and bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= FETCH;
            pc_r           <= RESET_PC;
            imem_address_r <= RESET_PC;
            imem_read_r    <= 1'b0;
            ir_r           <= lc3b_nop;
            ifid_pc_r      <= 16'h0000;
            valid_r        <= 1'b0;
        end else if (pc_load) begin
            pc_r    <= pc_target;
            ir_r    <= lc3b_nop;
            valid_r <= 1'b0;
            if (imem_read_r && !imem.imem_resp) begin
                // Keep the in-flight request stable and throw its data away later.
                state_r <= DRAIN;
            end else begin
                state_r        <= FETCH;
                imem_address_r <= pc_target;
                imem_read_r    <= 1'b1;
            end
        end else begin
            if (squash_ID) begin
                ir_r    <= lc3b_nop;
                valid_r <= 1'b0;
            end else if (stall_mem) begin
                ir_r    <= ir_r;
            end else if (gen_bubble) begin
                if (ctl_s) begin
                    ir_r    <= lc3b_nop;
                    valid_r <= 1'b0;
                end else begin
                    ir_r    <= ir_r;
                end
            end else if (load_ifid_s) begin
                ir_r      <= load_ir_s;
                ifid_pc_r <= load_pc_s;
                valid_r   <= 1'b1;
            end else begin
                ir_r    <= ir_r;
            end

            case (state_r)
                FETCH: begin
                    if (imem_read_r) begin
                        if (imem.imem_resp) begin
                            if (adv_s) begin
                                pc_r           <= pc_inc(pc_r);
                                imem_address_r <= pc_inc(pc_r);
                                imem_read_r    <= 1'b1;
                            end else begin
`ifdef IF_STAGE_SKID_EN
                                if (!squash_ID) begin
                                    pc_r    <= pc_inc(pc_r);
                                    state_r <= BUFFERED;
                                end else begin
                                    pc_r    <= pc_r;
                                end
`endif
                                imem_read_r <= 1'b0;
                            end
                        end else begin
                            imem_read_r <= 1'b1;
                        end
                    end else begin
                        if (adv_s) begin
                            imem_address_r <= pc_r;
                            imem_read_r    <= 1'b1;
                        end else begin
                            imem_read_r    <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (imem.imem_resp) begin
                        state_r        <= FETCH;
                        imem_address_r <= pc_r;
                        imem_read_r    <= adv_s;
                    end else begin
                        imem_read_r    <= 1'b1;
                    end
                end
`ifdef IF_STAGE_SKID_EN
                BUFFERED: begin
                    if (squash_ID || adv_s) begin
                        state_r        <= FETCH;
                        imem_address_r <= pc_r;
                        imem_read_r    <= adv_s;
                    end else begin
                        imem_read_r    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r        <= FETCH;
                    imem_address_r <= pc_r;
                    imem_read_r    <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_address = imem_address_r;
    assign imem.imem_read    = imem_read_r;
    assign IF_ID_ir          = ir_r;
    assign IF_ID_pc          = ifid_pc_r;
    assign IF_ID_valid       = valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        gen_bubble;
    logic        squash_ID;
    logic        stall_mem;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] IF_ID_ir;
    logic [15:0] IF_ID_pc;
    logic        IF_ID_valid;

    if_stage_if bus ();

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .gen_bubble  (gen_bubble),
        .squash_ID   (squash_ID),
        .stall_mem   (stall_mem),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .IF_ID_ir    (IF_ID_ir),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_valid (IF_ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the stage should present after each edge.
    logic [15:0] m_pc, m_ir, m_ifpc, m_addr, m_buf_ir, m_buf_pc;
    logic        m_valid, m_read, m_drain, m_buf;

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 16'h0000; m_ifpc = 16'h0000; m_valid = 1'b0;
        m_read = 1'b0; m_addr = 16'h0000; m_drain = 1'b0; m_buf = 1'b0;
        m_buf_ir = 16'h0000; m_buf_pc = 16'h0000;
    endtask

    // One clock of the fetch rules, applied to the inputs currently driven.
    task automatic model_step();
        logic adv, ctl, take, skid;
        logic [3:0] op;
        op   = m_ir[15:12];
        adv  = !stall_mem && !gen_bubble;
        ctl  = (m_ir != 16'h0000) && (op == 4'h0 || op == 4'h4 || op == 4'hC || op == 4'hF);
        take = bus.imem_resp && m_read;
`ifdef IF_STAGE_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif
        if (pc_load) begin
            m_ir = 16'h0000; m_valid = 1'b0; m_pc = pc_target; m_buf = 1'b0;
            if (m_read && !bus.imem_resp) m_drain = 1'b1;
            else begin m_drain = 1'b0; m_addr = pc_target; m_read = 1'b1; end
        end else begin
            if (squash_ID) begin
                m_ir = 16'h0000; m_valid = 1'b0;
            end else if (!adv) begin
                if (!stall_mem && ctl) begin m_ir = 16'h0000; m_valid = 1'b0; end
            end else if (take && !m_drain) begin
                m_ir = bus.imem_rdata; m_ifpc = m_pc + 16'd2; m_valid = 1'b1;
            end else if (m_buf) begin
                m_ir = m_buf_ir; m_ifpc = m_buf_pc; m_valid = 1'b1;
            end
            if (m_drain) begin
                if (take) begin m_drain = 1'b0; m_addr = m_pc; m_read = adv; end
            end else if (m_buf) begin
                if (squash_ID || adv) begin m_buf = 1'b0; m_addr = m_pc; m_read = adv; end
            end else if (take) begin
                if (adv) begin
                    m_pc = m_pc + 16'd2; m_addr = m_pc;
                end else if (skid && !squash_ID) begin
                    m_buf = 1'b1; m_buf_ir = bus.imem_rdata; m_buf_pc = m_pc + 16'd2;
                    m_pc = m_pc + 16'd2; m_read = 1'b0;
                end else begin
                    m_read = 1'b0;
                end
            end else if (!m_read && adv) begin
                m_addr = m_pc; m_read = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, land on the next falling edge.
    task automatic drive_cycle(input logic resp, input logic [15:0] rdata, input logic bub,
                               input logic sq, input logic st, input logic ld, input logic [15:0] tgt);
        bus.imem_resp  = resp;
        bus.imem_rdata = rdata;
        gen_bubble     = bub;
        squash_ID      = sq;
        stall_mem      = st;
        pc_load        = ld;
        pc_target      = tgt;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic resp(input logic [15:0] d);
        drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_resp = 1'b0; bus.imem_rdata = 16'h0000;
        gen_bubble = 1'b0; squash_ID = 1'b0; stall_mem = 1'b0; pc_load = 1'b0; pc_target = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.imem_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", bus.imem_read); end
        checks++; if (bus.imem_address !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", bus.imem_address); end
        checks++; if (IF_ID_ir !== 16'h0000 || IF_ID_pc !== 16'h0000 || IF_ID_valid !== 1'b0) begin
            failures++; $display("FAIL rst_ifid got=%h/%h/%b exp=0000/0000/0", IF_ID_ir, IF_ID_pc, IF_ID_valid); end
        rst_n = 1'b1;
        idle();
        checks++; if (bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0000) begin
            failures++; $display("FAIL first_req got=%b@%h exp=1@0000", bus.imem_read, bus.imem_address); end
        resp(16'h1234);
        checks++; if (IF_ID_ir !== 16'h1234 || IF_ID_pc !== 16'h0002 || IF_ID_valid !== 1'b1) begin
            failures++; $display("FAIL first_load got=%h/%h/%b exp=1234/0002/1", IF_ID_ir, IF_ID_pc, IF_ID_valid); end
        checks++; if (bus.imem_address !== 16'h0002 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL next_addr got=%b@%h exp=1@0002", bus.imem_read, bus.imem_address); end
    endtask

    task automatic test_load_use();
        resp(16'h1042);
        drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (IF_ID_ir !== 16'h1042 || IF_ID_valid !== 1'b1) begin
            failures++; $display("FAIL bubble_hold got=%h/%b exp=1042/1", IF_ID_ir, IF_ID_valid); end
        checks++; if (bus.imem_address !== 16'h0004 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL bubble_pc got=%b@%h exp=1@0004", bus.imem_read, bus.imem_address); end
        resp(16'h0E05);
        checks++; if (IF_ID_ir !== 16'h0E05 || IF_ID_pc !== 16'h0006) begin
            failures++; $display("FAIL resume got=%h/%h exp=0E05/0006", IF_ID_ir, IF_ID_pc); end
    endtask

    task automatic test_control_flow();
        drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (IF_ID_ir !== 16'h0000 || IF_ID_valid !== 1'b0 || IF_ID_pc !== 16'h0006) begin
            failures++; $display("FAIL ctl_nop got=%h/%b/%h exp=0000/0/0006", IF_ID_ir, IF_ID_valid, IF_ID_pc); end
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        checks++; if (IF_ID_ir !== 16'h0000 || IF_ID_valid !== 1'b0) begin
            failures++; $display("FAIL squash got=%h/%b exp=0000/0", IF_ID_ir, IF_ID_valid); end
    endtask

    task automatic test_frozen_response();
        drive_cycle(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (bus.imem_read !== 1'b0 || IF_ID_ir !== 16'h0000) begin
            failures++; $display("FAIL frozen_resp got=%b/%h exp=0/0000", bus.imem_read, IF_ID_ir); end
        idle();
`ifdef IF_STAGE_SKID_EN
        checks++; if (IF_ID_ir !== 16'h7777 || bus.imem_address !== 16'h0008 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL skid_release got=%h %b@%h exp=7777 1@0008", IF_ID_ir, bus.imem_read, bus.imem_address); end
`else
        checks++; if (IF_ID_ir !== 16'h0000 || bus.imem_address !== 16'h0006 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL refetch got=%h %b@%h exp=0000 1@0006", IF_ID_ir, bus.imem_read, bus.imem_address); end
`endif
    endtask

    task automatic test_redirect_drain();
        logic [15:0] old_addr;
        old_addr = bus.imem_address;
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        checks++; if (bus.imem_address !== old_addr || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL drain_hold got=%b@%h exp=1@%h", bus.imem_read, bus.imem_address, old_addr); end
        resp(16'h9999);
        checks++; if (bus.imem_address !== 16'h0010 || IF_ID_ir !== 16'h0000) begin
            failures++; $display("FAIL drain_exit got=%h/%h exp=0010/0000", bus.imem_address, IF_ID_ir); end
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200);
        idle();
        checks++; if (bus.imem_address !== 16'h0010 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL drain_wait got=%b@%h exp=1@0010", bus.imem_read, bus.imem_address); end
        resp(16'hBEEF);
        checks++; if (IF_ID_ir !== 16'h0000 || IF_ID_valid !== 1'b0 || bus.imem_address !== 16'h0200) begin
            failures++; $display("FAIL drain_discard got=%h/%b@%h exp=0000/0@0200", IF_ID_ir, IF_ID_valid, bus.imem_address); end
        resp(16'h1111);
        checks++; if (IF_ID_ir !== 16'h1111 || IF_ID_pc !== 16'h0202) begin
            failures++; $display("FAIL post_drain got=%h/%h exp=1111/0202", IF_ID_ir, IF_ID_pc); end
    endtask

    task automatic test_redirect_idle_and_wrap();
        drive_cycle(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300);
        checks++; if (bus.imem_address !== 16'h0300 || bus.imem_read !== 1'b1 || IF_ID_ir !== 16'h0000) begin
            failures++; $display("FAIL load_idle got=%b@%h/%h exp=1@0300/0000", bus.imem_read, bus.imem_address, IF_ID_ir); end
        drive_cycle(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
        checks++; if (bus.imem_address !== 16'hFFFE || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL load_resp got=%b@%h exp=1@FFFE", bus.imem_read, bus.imem_address); end
        resp(16'hABCD);
        checks++; if (IF_ID_ir !== 16'hABCD || IF_ID_pc !== 16'h0000 || bus.imem_address !== 16'h0000) begin
            failures++; $display("FAIL wrap got=%h/%h@%h exp=ABCD/0000@0000", IF_ID_ir, IF_ID_pc, bus.imem_address); end
    endtask

    task automatic test_skid();
        drive_cycle(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        checks++; if (bus.imem_read !== 1'b0 || IF_ID_ir !== 16'hABCD) begin
            failures++; $display("FAIL stall_resp got=%b/%h exp=0/ABCD", bus.imem_read, IF_ID_ir); end
        idle();
`ifdef IF_STAGE_SKID_EN
        checks++; if (IF_ID_ir !== 16'h5555 || IF_ID_pc !== 16'h0002 || bus.imem_address !== 16'h0002) begin
            failures++; $display("FAIL skid_out got=%h/%h@%h exp=5555/0002@0002", IF_ID_ir, IF_ID_pc, bus.imem_address); end
`else
        checks++; if (IF_ID_ir !== 16'hABCD || bus.imem_address !== 16'h0000 || bus.imem_read !== 1'b1) begin
            failures++; $display("FAIL rerequest got=%h %b@%h exp=ABCD 1@0000", IF_ID_ir, bus.imem_read, bus.imem_address); end
        resp(16'h5555);
        checks++; if (IF_ID_ir !== 16'h5555 || IF_ID_pc !== 16'h0002) begin
            failures++; $display("FAIL refetch_load got=%h/%h exp=5555/0002", IF_ID_ir, IF_ID_pc); end
`endif
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_read !== 1'b0 || bus.imem_address !== 16'h0000 || IF_ID_ir !== 16'h0000 || IF_ID_valid !== 1'b0) begin
            failures++; $display("FAIL async_rst got=%b@%h/%h/%b exp=0@0000/0000/0", bus.imem_read, bus.imem_address, IF_ID_ir, IF_ID_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checks++; if (IF_ID_ir !== 16'h0000 || IF_ID_valid !== 1'b0 || bus.imem_read !== 1'b1 || bus.imem_address !== 16'h0000) begin
            failures++; $display("FAIL late_resp got=%h/%b %b@%h exp=0000/0 1@0000", IF_ID_ir, IF_ID_valid, bus.imem_read, bus.imem_address); end
    endtask

    task automatic test_random();
        logic [15:0] t;
        logic r;
        for (int i = 0; i < 3000; i++) begin
            t = 16'($urandom);
            r = m_read ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            drive_cycle(r, 16'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0,
                        $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, {t[15:1], 1'b0});
            checks++; if (bus.imem_read !== m_read) begin
                failures++; $display("FAIL rnd_read cyc=%0d got=%b exp=%b", i, bus.imem_read, m_read); end
            checks++; if (bus.imem_address !== m_addr) begin
                failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.imem_address, m_addr); end
            checks++; if (IF_ID_ir !== m_ir) begin
                failures++; $display("FAIL rnd_ir cyc=%0d got=%h exp=%h", i, IF_ID_ir, m_ir); end
            checks++; if (IF_ID_pc !== m_ifpc) begin
                failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, IF_ID_pc, m_ifpc); end
            checks++; if (IF_ID_valid !== m_valid) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, IF_ID_valid, m_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_control_flow();
        test_frozen_response();
        test_redirect_drain();
        test_redirect_idle_and_wrap();
        test_skid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
